// File: rtl/sweep_pkg.sv
// Shared types for the exhaustive-sweep stimulus engine.
// Holds the FSM state encoding and the {vec, resp, last} record carried by the FIFO.
package sweep_pkg;

    // Widest vector/response one record can carry. Instances narrower than this
    // zero-extend into the record, and the unused upper bits are never read.
    localparam int VEC_MAX  = 32;
    localparam int RESP_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DRAIN
    } sweep_state_e;

    typedef struct packed {
        logic [VEC_MAX-1:0]  vec;
        logic [RESP_MAX-1:0] resp;
        logic                last;
    } sweep_rec_t;

endpackage

// File: rtl/sweep_rec_fifo.sv
// DEPTH-entry synchronous record FIFO with flush; head is zero while empty.
// Ports: clk, rst_n (async low), flush, push/wr_rec, pop/rd_rec, full, empty.
module sweep_rec_fifo
    import sweep_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  sweep_rec_t wr_rec,
    input  logic       pop,
    output sweep_rec_t rd_rec,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sweep_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop at full frees no slot until the next cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_rec  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wr_rec;
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Drives every W-bit vector in ascending order, samples the response after a settle
// time and streams {vec, resp, last} records. Ports: CK, reset, start, abort,
// vec_out, resp_in, rec_valid/rec_ready/rec_vec/rec_resp/rec_last, busy, done.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int W      = 7,
    parameter int RW     = 1,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 4
) (
    input  logic          CK,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [W-1:0]  vec_out,
    input  logic [RW-1:0] resp_in,
    output logic          rec_valid,
    input  logic          rec_ready,
    output logic [W-1:0]  rec_vec,
    output logic [RW-1:0] rec_resp,
    output logic          rec_last,
    output logic          busy,
    output logic          done
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] RELOAD   = SW'(SETTLE - 1);
    localparam logic [W:0]    LAST_VEC = {1'b0, {W{1'b1}}};

    sweep_state_e  state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [W:0]    cnt_q, cnt_d;
    logic          done_q, done_d;

    logic          push;
    logic          pop;
    logic          flush;
    logic          full;
    logic          empty;
    logic          is_last;
    sweep_rec_t    wr_rec;
    sweep_rec_t    head;
    logic          unused_hi;

    assign is_last   = (cnt_q == LAST_VEC);
    assign vec_out   = cnt_q[W-1:0];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rec_valid = !empty;
    assign pop       = rec_valid && rec_ready;
    assign rec_vec   = head.vec[W-1:0];
    assign rec_resp  = head.resp[RW-1:0];
    assign rec_last  = head.last;
    assign unused_hi = |(head.vec >> W) | |(head.resp >> RW);

    always_comb begin
        wr_rec      = '0;
        wr_rec.vec  = VEC_MAX'(cnt_q[W-1:0]);
        wr_rec.resp = RESP_MAX'(resp_in);
        wr_rec.last = is_last;
    end

    // The state literal SETTLE is shadowed by the parameter of the same name,
    // so it is always referenced through the package scope.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = sweep_pkg::SETTLE;
                        scnt_d  = RELOAD;
                        cnt_d   = '0;
                    end
                end
                sweep_pkg::SETTLE: begin
                    if (scnt_q == '0)
                        state_d = SAMPLE;
                    else
                        scnt_d = scnt_q - SW'(1);
                end
                SAMPLE: begin
                    if (!full) begin
                        push = 1'b1;
                        if (is_last) begin
                            state_d = DRAIN;
                        end else begin
                            cnt_d   = cnt_q + (W+1)'(1);
                            scnt_d  = RELOAD;
                            state_d = sweep_pkg::SETTLE;
                        end
                    end
                end
                DRAIN: begin
                    // Leaving on the pop of the last record puts done and the
                    // falling busy in the cycle right after that pop.
                    if (empty || (pop && head.last)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    sweep_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (CK),
        .rst_n  (reset),
        .flush  (flush),
        .push   (push),
        .wr_rec (wr_rec),
        .pop    (pop),
        .rd_rec (head),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: three instances (parity DUT, piped DUT, W=1),
// backpressure, abort, restart, busy-start and mid-sweep reset scenarios.
module tb_sweep_sequencer;

    typedef struct {
        int vec;
        int resp;
        bit last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic       start0, abort0, rdy0;
    logic [6:0] vec0, rec_vec0;
    logic       resp0, rv0, rec_resp0, rec_last0, busy0, done0;

    logic       start1, abort1, rdy1;
    logic [6:0] vec1, rec_vec1, resp1, rec_resp1, p1, p2;
    logic       rv1, rec_last1, busy1, done1;

    logic       start2, abort2, rdy2;
    logic       vec2, rec_vec2, resp2, rec_resp2, rv2, rec_last2, busy2, done2;

    int accepted0;
    int n_done0, n_done1, n_done2;
    bit last_acc0;
    int prev1;
    bit have_prev1;

    assign resp0 = ^vec0;
    assign resp1 = p2;
    assign resp2 = vec2;

    always @(posedge clk) begin
        p1 <= vec1 ^ 7'h55;
        p2 <= p1;
    end

    sweep_sequencer #(.W(7), .RW(1), .SETTLE(1), .DEPTH(4)) dut0 (
        .CK(clk), .reset(rst_n), .start(start0), .abort(abort0),
        .vec_out(vec0), .resp_in(resp0), .rec_valid(rv0), .rec_ready(rdy0),
        .rec_vec(rec_vec0), .rec_resp(rec_resp0), .rec_last(rec_last0),
        .busy(busy0), .done(done0)
    );

    sweep_sequencer #(.W(7), .RW(7), .SETTLE(3), .DEPTH(4)) dut1 (
        .CK(clk), .reset(rst_n), .start(start1), .abort(abort1),
        .vec_out(vec1), .resp_in(resp1), .rec_valid(rv1), .rec_ready(rdy1),
        .rec_vec(rec_vec1), .rec_resp(rec_resp1), .rec_last(rec_last1),
        .busy(busy1), .done(done1)
    );

    sweep_sequencer #(.W(1), .RW(1), .SETTLE(1), .DEPTH(4)) dut2 (
        .CK(clk), .reset(rst_n), .start(start2), .abort(abort2),
        .vec_out(vec2), .resp_in(resp2), .rec_valid(rv2), .rec_ready(rdy2),
        .rec_vec(rec_vec2), .rec_resp(rec_resp2), .rec_last(rec_last2),
        .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vec0(input int v);
        int i;
        i = 0;
        while (int'(vec0) != v && i < 1000) begin
            step();
            i++;
        end
        chk("reach_vec0", 32'(vec0), v);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy0 || busy1 || busy2) && i < 3000) begin
            step();
            i++;
        end
        chk("sweeps_idle", {busy0, busy1, busy2}, 0);
    endtask

    task automatic load_q0();
        for (int k = 0; k < 128; k++)
            q0.push_back('{vec: k, resp: $countones(k) & 1, last: (k == 127)});
    endtask

    // Monitor for the parity instance: record order, content and done timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_acc0 = 1'b0;
        end else begin
            if (done0 || last_acc0) begin
                chk("done0_after_last", done0, last_acc0);
                if (done0) chk("busy0_low_at_done", busy0, 0);
            end
            if (done0) n_done0++;
            last_acc0 = 1'b0;
            if (rv0 && rdy0) begin
                if (q0.size() == 0) begin
                    chk("rec0_unexpected", rv0, 0);
                end else begin
                    e = q0.pop_front();
                    chk("rec0_vec", rec_vec0, e.vec);
                    chk("rec0_resp", rec_resp0, e.resp);
                    chk("rec0_last", rec_last0, e.last);
                    accepted0++;
                    last_acc0 = e.last;
                end
            end
        end
    end

    // Monitor for the piped instance: content plus push spacing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done1) n_done1++;
            if (rv1 && rdy1) begin
                if (q1.size() == 0) begin
                    chk("rec1_unexpected", rv1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("rec1_vec", rec_vec1, e.vec);
                    chk("rec1_resp", rec_resp1, e.resp);
                    chk("rec1_last", rec_last1, e.last);
                    if (have_prev1) chk("rec1_spacing", cyc - prev1, 4);
                    prev1 = cyc;
                    have_prev1 = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done2) n_done2++;
            if (rv2 && rdy2) begin
                if (q2.size() == 0) begin
                    chk("rec2_unexpected", rv2, 0);
                end else begin
                    e = q2.pop_front();
                    chk("rec2_vec", rec_vec2, e.vec);
                    chk("rec2_resp", rec_resp2, e.resp);
                    chk("rec2_last", rec_last2, e.last);
                end
            end
        end
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; accepted0 = 0;
        n_done0 = 0; n_done1 = 0; n_done2 = 0;
        last_acc0 = 0; prev1 = 0; have_prev1 = 0;
        rst_n = 1'b0;
        start0 = 0; start1 = 0; start2 = 0;
        abort0 = 0; abort1 = 0; abort2 = 0;
        rdy0 = 1; rdy1 = 1; rdy2 = 1;
        repeat (3) step();
        chk("rst_vec0", vec0, 0);
        chk("rst_valid0", rv0, 0);
        chk("rst_rec0", {rec_vec0, rec_resp0, rec_last0}, 0);
        chk("rst_busy_done0", {busy0, done0}, 0);
        rst_n = 1'b1;
        step();

        // Full sweeps on all three instances, with a 20-cycle stall on dut0.
        load_q0();
        for (int k = 0; k < 128; k++)
            q1.push_back('{vec: k, resp: k ^ 'h55, last: (k == 127)});
        q2.push_back('{vec: 0, resp: 0, last: 0});
        q2.push_back('{vec: 1, resp: 1, last: 1});
        start0 = 1; start1 = 1; start2 = 1;
        step();
        start0 = 0; start1 = 0; start2 = 0;
        chk("busy0_after_start", busy0, 1);
        chk("vec0_after_start", vec0, 0);
        wait_vec0('h10);
        rdy0 = 0;
        repeat (15) step();
        chk("stall_vec0_a", vec0, accepted0 + 4);
        repeat (5) step();
        chk("stall_vec0_b", vec0, accepted0 + 4);
        chk("stall_valid0", rv0, 1);
        rdy0 = 1;
        wait_idle();
        repeat (2) step();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("done0_count", n_done0, 1);
        chk("done1_count", n_done1, 1);
        chk("done2_count", n_done2, 1);
        chk("vec0_idle", vec0, 0);

        // Abort at 0x2A with three records queued.
        accepted0 = 0;
        load_q0();
        start0 = 1;
        step();
        start0 = 0;
        wait_vec0('h28);
        rdy0 = 0;
        wait_vec0('h2A);
        chk("accepted_before_abort", accepted0, 'h27);
        abort0 = 1;
        step();
        abort0 = 0;
        q0.delete();
        chk("abort_valid0", rv0, 0);
        chk("abort_vec0", vec0, 0);
        chk("abort_busy0", busy0, 0);
        chk("abort_done0", done0, 0);
        rdy0 = 1;
        repeat (5) step();
        chk("abort_no_done", n_done0, 1);

        // Restart from 0, with a start pulse while busy that must be ignored.
        load_q0();
        start0 = 1;
        step();
        start0 = 0;
        chk("restart_vec0", vec0, 0);
        wait_vec0('h30);
        start0 = 1;
        step();
        start0 = 0;
        chk("start_busy_ignored", busy0, 1);
        wait_idle();
        repeat (2) step();
        chk("q0_restart_drained", q0.size(), 0);
        chk("done0_restart", n_done0, 2);

        // Asynchronous reset mid-sweep at 0x55.
        load_q0();
        start0 = 1;
        step();
        start0 = 0;
        wait_vec0('h55);
        rst_n = 1'b0;
        #1;
        chk("arst_vec0", vec0, 0);
        chk("arst_valid0", rv0, 0);
        chk("arst_rec0", {rec_vec0, rec_resp0, rec_last0}, 0);
        chk("arst_busy_done0", {busy0, done0}, 0);
        q0.delete();
        step();
        rst_n = 1'b1;
        step();
        start0 = 1;
        abort0 = 1;
        step();
        start0 = 0;
        abort0 = 0;
        chk("start_abort_idle", busy0, 0);
        repeat (3) step();
        chk("idle_vec0", vec0, 0);
        chk("idle_valid0", rv0, 0);
        chk("done0_final", n_done0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
